// File: rtl/ext_mem_responder.sv
// Memory-side responder: byte-masked writes into a word array, in-order reads after LATENCY cycles.
// Define MEM_RESP_STALL_EN to add LFSR-driven pseudo-random readiness stalls.

`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef CPU_ADDR_BITS
`define CPU_ADDR_BITS 32
`endif

module ext_mem_responder #(
  parameter int ADDR_BITS       = `CPU_ADDR_BITS - $clog2(`MEM_DATA_BITS/8),
  parameter int DEPTH_BITS      = 10,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_req_valid,
  output logic                         mem_req_ready,
  input  logic [ADDR_BITS-1:0]         mem_req_addr,
  input  logic                         mem_req_rw,
  input  logic                         mem_req_data_valid,
  output logic                         mem_req_data_ready,
  input  logic [`MEM_DATA_BITS-1:0]    mem_req_data_bits,
  input  logic [`MEM_DATA_BITS/8-1:0]  mem_req_data_mask,
  output logic                         mem_resp_valid,
  output logic [`MEM_DATA_BITS-1:0]    mem_resp_data
);

  localparam int W  = `MEM_DATA_BITS;
  localparam int NB = W / 8;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, WDATA} state_t;

  state_t                state_reg;
  logic                  req_ready_reg;
  logic                  data_ready_reg;
  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         count_next;
  logic [DEPTH_BITS-1:0] wr_idx_reg;
  logic                  stall_next;

  logic [W-1:0] mem [0:(1<<DEPTH_BITS)-1];
  logic [W-1:0] read_word;
  logic [W-1:0] merged_word;

  logic         pipe_valid_reg [LATENCY];
  logic [W-1:0] pipe_data_reg  [LATENCY];
  logic         stage_valid_in [LATENCY];
  logic [W-1:0] stage_data_in  [LATENCY];

  logic read_fire;
  logic write_fire;
  logic data_fire;
  logic unused_addr_bits;

  assign unused_addr_bits = ^mem_req_addr[ADDR_BITS-1:DEPTH_BITS];

  assign read_fire  = mem_req_valid && req_ready_reg && !mem_req_rw;
  assign write_fire = mem_req_valid && req_ready_reg && mem_req_rw;
  assign data_fire  = mem_req_data_valid && data_ready_reg;

  assign mem_req_ready      = req_ready_reg;
  assign mem_req_data_ready = data_ready_reg;
  assign mem_resp_valid     = pipe_valid_reg[LATENCY-1];
  assign mem_resp_data      = pipe_data_reg[LATENCY-1];

  always_comb begin
    count_next = count_reg + CW'(read_fire) - CW'(mem_resp_valid);
  end

`ifdef MEM_RESP_STALL_EN
  logic [7:0] lfsr_reg;
  logic [7:0] lfsr_next;

  // Fibonacci taps 8,6,5,4; the registered readies look at the value the LFSR will hold next cycle.
  assign lfsr_next  = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
  assign stall_next = (lfsr_next[1:0] == 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_reg <= 8'hA5;
    else        lfsr_reg <= lfsr_next;
  end
`else
  assign stall_next = 1'b0;
`endif

  // Readies are registered from next-cycle state/count so they are valid for the whole cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      req_ready_reg  <= 1'b0;
      data_ready_reg <= 1'b0;
      count_reg      <= '0;
      wr_idx_reg     <= '0;
    end else begin
      count_reg <= count_next;
      case (state_reg)
        IDLE: begin
          if (write_fire) begin
            state_reg      <= WDATA;
            wr_idx_reg     <= mem_req_addr[DEPTH_BITS-1:0];
            req_ready_reg  <= 1'b0;
            data_ready_reg <= !stall_next;
          end else begin
            req_ready_reg  <= (count_next < MAX_CNT) && !stall_next;
            data_ready_reg <= 1'b0;
          end
        end
        WDATA: begin
          if (data_fire) begin
            state_reg      <= IDLE;
            req_ready_reg  <= (count_next < MAX_CNT) && !stall_next;
            data_ready_reg <= 1'b0;
          end else begin
            req_ready_reg  <= 1'b0;
            data_ready_reg <= !stall_next;
          end
        end
        default: begin
          state_reg      <= IDLE;
          req_ready_reg  <= 1'b0;
          data_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign read_word = mem[mem_req_addr[DEPTH_BITS-1:0]];

  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    assign merged_word[8*gi +: 8] = mem_req_data_mask[gi] ? mem_req_data_bits[8*gi +: 8]
                                                          : mem[wr_idx_reg][8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (data_fire) mem[wr_idx_reg] <= merged_word;
  end

  always_comb begin
    stage_valid_in[0] = read_fire;
    stage_data_in[0]  = read_word;
    for (int i = 1; i < LATENCY; i++) begin
      stage_valid_in[i] = pipe_valid_reg[i-1];
      stage_data_in[i]  = pipe_data_reg[i-1];
    end
  end

  // The last stage only loads data on a valid beat so the response data holds between beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid_reg[i] <= 1'b0;
        pipe_data_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid_reg[i] <= stage_valid_in[i];
        if (i != LATENCY-1 || stage_valid_in[i]) pipe_data_reg[i] <= stage_data_in[i];
      end
    end
  end

endmodule
